// File: rtl/series_pkg.sv
// Shared types and constants for the series-evaluation sequencer.
package series_pkg;

   // Controller state encoding, visible to the bench through the debug port.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SQ    = 3'd2,
      MUL_X = 3'd3,
      MUL_C = 3'd4,
      CHECK = 3'd5,
      DONE  = 3'd6
   } series_state_t;

   localparam int          ROM_IDX_W = 3;
   localparam logic        SUB_ADD   = 1'b1;   // accumulator computes ans + tmp
   localparam logic        SUB_SUB   = 1'b0;   // accumulator computes ans - tmp
   localparam logic [15:0] Q_ONE     = 16'h0100;

endpackage

// File: rtl/series_ctrl_if.sv
// Control/status bundle between the sequencer and the Q8.8 series datapath.
// There is no handshake here: every control is a level held for exactly the
// cycle it applies to, and less_cmp is a combinational status from the
// datapath's registered tmp, valid whenever it is sampled.
interface series_ctrl_if;
   import series_pkg::*;

   logic                 less_cmp;
   logic                 s1_rom;
   logic                 s1_x;
   logic                 s2_tmp;
   logic                 s2_x;
   logic [ROM_IDX_W-1:0] s3;
   logic                 s4_in;
   logic                 s4_mult;
   logic                 ld_x;
   logic                 ld_y;
   logic                 ld_tmp;
   logic                 ld_ans;
   logic                 init_tmp;
   logic                 init_ans;
   logic                 sub;

   // Sequencer side: drives every datapath control, reads the comparator.
   modport ctrl (
      input  less_cmp,
      output s1_rom, s1_x, s2_tmp, s2_x, s3, s4_in, s4_mult,
             ld_x, ld_y, ld_tmp, ld_ans, init_tmp, init_ans, sub
   );

   // Datapath side.
   modport dp (
      output less_cmp,
      input  s1_rom, s1_x, s2_tmp, s2_x, s3, s4_in, s4_mult,
             ld_x, ld_y, ld_tmp, ld_ans, init_tmp, init_ans, sub
   );

endinterface

// File: rtl/series_ctrl.sv
// Sequencer for the fixed-point series datapath: load operands, optionally
// square x, then per term multiply by x, multiply by rom[k], check and
// accumulate until the term falls to the y threshold or MAX_TERMS is hit.
module series_ctrl
   import series_pkg::*;
#(
   parameter int MAX_TERMS = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          alt,
   input  logic          sq,
   series_ctrl_if.ctrl   dp,
   output logic          busy,
   output logic          done,
   output logic [3:0]    n_terms,
   output series_state_t dbg_state
);

   localparam logic [ROM_IDX_W-1:0] K_LAST = ROM_IDX_W'(MAX_TERMS - 1);

   series_state_t        state_q;
   logic [ROM_IDX_W-1:0] k_q;
   logic [3:0]           n_terms_q;
   logic                 alt_q;
   logic                 sq_q;

   logic                 s1_rom_d;
   logic                 s2_x_d;
   logic [ROM_IDX_W-1:0] s3_d;
   logic                 s4_in_d;
   logic                 ld_x_d;
   logic                 ld_y_d;
   logic                 ld_tmp_d;
   logic                 ld_ans_d;
   logic                 init_tmp_d;
   logic                 init_ans_d;
   logic                 sub_d;

   // State transitions, term counter, term count and latched run options.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         n_terms_q <= '0;
         alt_q     <= 1'b0;
         sq_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  alt_q   <= alt;
                  sq_q    <= sq;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               k_q       <= '0;
               n_terms_q <= '0;
               state_q   <= sq_q ? SQ : MUL_X;
            end
            SQ:    state_q <= MUL_X;
            MUL_X: state_q <= MUL_C;
            MUL_C: state_q <= CHECK;
            CHECK: begin
               if (dp.less_cmp) begin
                  state_q <= DONE;
               end else begin
                  n_terms_q <= {1'b0, k_q} + 4'd1;
                  if (k_q == K_LAST) begin
                     state_q <= DONE;
                  end else begin
                     k_q     <= k_q + 1'b1;
                     state_q <= MUL_X;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Datapath control decode; IDLE (and therefore reset) yields all-zero controls.
   always_comb begin
      s1_rom_d   = 1'b0;
      s2_x_d     = 1'b0;
      s3_d       = '0;
      s4_in_d    = 1'b0;
      ld_x_d     = 1'b0;
      ld_y_d     = 1'b0;
      ld_tmp_d   = 1'b0;
      ld_ans_d   = 1'b0;
      init_tmp_d = 1'b0;
      init_ans_d = 1'b0;
      // Sign follows the term index even when no accumulate happens.
      sub_d      = (state_q == IDLE) ? SUB_SUB : (alt_q ? k_q[0] : SUB_ADD);
      case (state_q)
         LOAD: begin
            s4_in_d    = 1'b1;
            ld_x_d     = 1'b1;
            ld_y_d     = 1'b1;
            init_tmp_d = 1'b1;
            init_ans_d = 1'b1;
         end
         SQ: begin
            s2_x_d = 1'b1;
            ld_x_d = 1'b1;
         end
         MUL_X: begin
            ld_tmp_d = 1'b1;
         end
         MUL_C: begin
            s1_rom_d = 1'b1;
            s3_d     = k_q;
            ld_tmp_d = 1'b1;
         end
         CHECK: begin
            ld_ans_d = ~dp.less_cmp;
         end
         default: ;
      endcase
   end

   assign dp.s1_rom   = s1_rom_d;
   assign dp.s1_x     = ~s1_rom_d;
   assign dp.s2_x     = s2_x_d;
   assign dp.s2_tmp   = ~s2_x_d;
   assign dp.s3       = s3_d;
   assign dp.s4_in    = s4_in_d;
   assign dp.s4_mult  = ~s4_in_d;
   assign dp.ld_x     = ld_x_d;
   assign dp.ld_y     = ld_y_d;
   assign dp.ld_tmp   = ld_tmp_d;
   assign dp.ld_ans   = ld_ans_d;
   assign dp.init_tmp = init_tmp_d;
   assign dp.init_ans = init_ans_d;
   assign dp.sub      = sub_d;

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign n_terms   = n_terms_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_series_ctrl.sv
// Bench for series_ctrl: two instances (MAX_TERMS 8 and 4) run side by side.
// Each run is planned as a per-cycle list of expected controls built from the
// sequencing rules, then replayed cycle by cycle against both instances.
module tb_series_ctrl;
   import series_pkg::*;

   typedef struct {
      logic [17:0] v;      // expected packed controls
      logic [17:0] m;      // compare mask (sub is don't-care outside CHECK)
      logic        lc;     // less_cmp to present this cycle
      logic        st;     // start to present this cycle
      logic        chk_n;  // compare n_terms this cycle
      logic [3:0]  n;
   } rec_t;

   localparam logic [17:0] M_ALL   = 18'h3FFFF;
   localparam logic [17:0] M_NOSUB = 18'h3FFFE;

   logic clk, rst_n;
   logic start8, start4, alt, sq;
   logic busy8, done8, busy4, done4;
   logic [3:0] n8, n4;
   series_state_t st8, st4;
   logic [17:0] obs8, obs4;

   int n_checks = 0;
   int n_errors = 0;
   rec_t q8[$];
   rec_t q4[$];

   series_ctrl_if if8 ();
   series_ctrl_if if4 ();

   series_ctrl #(.MAX_TERMS(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .alt(alt), .sq(sq), .dp(if8),
      .busy(busy8), .done(done8), .n_terms(n8), .dbg_state(st8));

   series_ctrl #(.MAX_TERMS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .alt(alt), .sq(sq), .dp(if4),
      .busy(busy4), .done(done4), .n_terms(n4), .dbg_state(st4));

   assign obs8 = {busy8, done8, if8.s1_rom, if8.s1_x, if8.s2_x, if8.s2_tmp, if8.s3,
                  if8.s4_in, if8.s4_mult, if8.ld_x, if8.ld_y, if8.ld_tmp, if8.ld_ans,
                  if8.init_tmp, if8.init_ans, if8.sub};
   assign obs4 = {busy4, done4, if4.s1_rom, if4.s1_x, if4.s2_x, if4.s2_tmp, if4.s3,
                  if4.s4_in, if4.s4_mult, if4.ld_x, if4.ld_y, if4.ld_tmp, if4.ld_ans,
                  if4.init_tmp, if4.init_ans, if4.sub};

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [17:0] mk(input logic b, input logic d, input logic r,
                                      input logic x2, input logic [2:0] s3, input logic s4,
                                      input logic lx, input logic ly, input logic lt,
                                      input logic la, input logic it, input logic ia,
                                      input logic sb);
      return {b, d, r, ~r, x2, ~x2, s3, s4, ~s4, lx, ly, lt, la, it, ia, sb};
   endfunction

   function automatic rec_t idle_rec();
      rec_t r;
      r.v = mk(0,0,0,0,3'd0,0,0,0,0,0,0,0,0);
      r.m = M_ALL;
      r.lc = 1'b0;
      r.st = 1'b0;
      r.chk_n = 1'b0;
      r.n = 4'd0;
      return r;
   endfunction

   task automatic push(input int inst, input rec_t r);
      if (inst == 8) q8.push_back(r);
      else           q4.push_back(r);
   endtask

   // Expected cycle list for one run, straight from the sequencing rules.
   task automatic plan(input int inst, input int mt, input logic a, input logic s, input int stop_k);
      rec_t r;
      int n_exp;
      logic [2:0] kv;
      r = idle_rec(); r.st = 1'b1; push(inst, r);
      r = idle_rec(); r.m = M_NOSUB; r.st = 1'($urandom_range(0, 1));
      r.v = mk(1,0,0,0,3'd0,1,1,1,0,0,1,1,0); push(inst, r);
      if (s) begin
         r = idle_rec(); r.m = M_NOSUB; r.st = 1'($urandom_range(0, 1));
         r.v = mk(1,0,0,1,3'd0,0,1,0,0,0,0,0,0); push(inst, r);
      end
      n_exp = mt;
      for (int k = 0; k < mt; k++) begin
         kv = 3'(k);
         r = idle_rec(); r.m = M_NOSUB; r.st = 1'($urandom_range(0, 1));
         r.v = mk(1,0,0,0,3'd0,0,0,0,1,0,0,0,0); push(inst, r);
         r = idle_rec(); r.m = M_NOSUB; r.st = 1'($urandom_range(0, 1));
         r.v = mk(1,0,1,0,kv,0,0,0,1,0,0,0,0); push(inst, r);
         r = idle_rec(); r.st = 1'($urandom_range(0, 1));
         r.lc = (k == stop_k);
         r.v = mk(1,0,0,0,3'd0,0,0,0,0,~r.lc,0,0, a ? kv[0] : 1'b1); push(inst, r);
         if (k == stop_k) begin
            n_exp = k;
            break;
         end
      end
      r = idle_rec(); r.m = M_NOSUB; r.st = 1'($urandom_range(0, 1));
      r.v = mk(1,1,0,0,3'd0,0,0,0,0,0,0,0,0);
      r.chk_n = 1'b1; r.n = 4'(n_exp); push(inst, r);
   endtask

   // One cycle: present inputs at the falling edge, compare shortly after.
   task automatic step();
      rec_t r8, r4;
      @(negedge clk);
      r8 = (q8.size() > 0) ? q8.pop_front() : idle_rec();
      r4 = (q4.size() > 0) ? q4.pop_front() : idle_rec();
      start8 = r8.st; if8.less_cmp = r8.lc;
      start4 = r4.st; if4.less_cmp = r4.lc;
      #1;
      check_val("ctl8", 32'(obs8 & r8.m), 32'(r8.v & r8.m));
      check_val("ctl4", 32'(obs4 & r4.m), 32'(r4.v & r4.m));
      if (r8.chk_n) check_val("nterms8", 32'(n8), 32'(r8.n));
      if (r4.chk_n) check_val("nterms4", 32'(n4), 32'(r4.n));
   endtask

   task automatic reset_check(input string tag);
      check_val({tag, "_ctl8"}, 32'(obs8), 32'(mk(0,0,0,0,3'd0,0,0,0,0,0,0,0,0)));
      check_val({tag, "_ctl4"}, 32'(obs4), 32'(mk(0,0,0,0,3'd0,0,0,0,0,0,0,0,0)));
      check_val({tag, "_n8"}, 32'(n8), 32'd0);
      check_val({tag, "_n4"}, 32'(n4), 32'd0);
   endtask

   // Launch both instances; abort >= 0 pulls reset after that many cycles.
   task automatic run_pair(input logic a, input logic s, input int stop8, input int stop4,
                           input int abort);
      int cyc;
      alt = a;
      sq  = s;
      plan(8, 8, a, s, stop8);
      plan(4, 4, a, s, stop4);
      cyc = 0;
      while (q8.size() > 0 || q4.size() > 0) begin
         step();
         if (cyc == abort) begin
            rst_n = 1'b0;
            #1;
            reset_check("midrst");
            q8.delete();
            q4.delete();
            start8 = 1'b0;
            start4 = 1'b0;
            #1 rst_n = 1'b1;
            for (int i = 0; i < 3; i++) step();
         end
         cyc++;
         if (cyc > 200) begin
            check_val("run_timeout", 32'(cyc), 32'd200);
            q8.delete();
            q4.delete();
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start8 = 1'b0; start4 = 1'b0; alt = 1'b0; sq = 1'b0;
      if8.less_cmp = 1'b0; if4.less_cmp = 1'b0;
      #3;
      reset_check("por");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) step();

      run_pair(1'b0, 1'b0, 8, 4, -1);   // full runs, no early stop
      run_pair(1'b0, 1'b0, 2, 2, -1);   // stop in third CHECK
      run_pair(1'b1, 1'b1, 8, 4, -1);   // alternating with square
      run_pair(1'b0, 1'b0, 8, 4, 3);    // reset during first MUL_C
      run_pair(1'b1, 1'b0, 0, 0, -1);   // stop on very first term
      for (int i = 0; i < 24; i++) begin
         run_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 8), $urandom_range(0, 4), -1);
      end
      for (int i = 0; i < 2; i++) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
